// File: rtl/apb_gpio_arbiter.sv
// Round-robin two-requester APB master for the GPIO slave port.
// One command per grant, with a wait-state timeout that turns a hung slave into an error.
module apb_gpio_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_write,
  input  logic [2*ADDR_W-1:0]      req_addr,
  input  logic [2*DATA_W-1:0]      req_wdata,
  input  logic [2*(DATA_W/8)-1:0]  req_strb,
  output logic [1:0]               rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PWRITE,
  output logic [DATA_W/8-1:0]      PSTRB,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [CNT_W-1:0]  wait_cnt;

  logic              any_req;
  logic              gnt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;
  logic              to_hit;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    any_req   = |req_valid;
    gnt       = (&req_valid) ? ~last_grant : req_valid[1];
    sel_write = gnt ? req_write[1] : req_write[0];
    sel_addr  = gnt ? req_addr[2*ADDR_W-1:ADDR_W]
                    : req_addr[ADDR_W-1:0];
    sel_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W]
                    : req_wdata[DATA_W-1:0];
    sel_strb  = gnt ? req_strb[2*STRB_W-1:STRB_W]
                    : req_strb[STRB_W-1:0];
    req_ready = '0;
    if (state == IDLE && any_req) req_ready[gnt] = 1'b1;
    to_hit    = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PSTRB      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            PADDR      <= sel_addr;
            PWRITE     <= sel_write;
            PWDATA     <= sel_wdata;
            PSTRB      <= sel_write ? sel_strb : '0;
            last_grant <= gnt;
            wait_cnt   <= '0;
            PSEL       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata             <= PWRITE ? '0 : PRDATA;
            rsp_err               <= PSLVERR;
            rsp_valid[last_grant] <= 1'b1;
            PSEL                  <= 1'b0;
            PENABLE               <= 1'b0;
            state                 <= IDLE;
          end else if (to_hit) begin
            rsp_rdata             <= '0;
            rsp_err               <= 1'b1;
            rsp_valid[last_grant] <= 1'b1;
            PSEL                  <= 1'b0;
            PENABLE               <= 1'b0;
            state                 <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Scoreboard bench for apb_gpio_arbiter: directed vectors, queued expectations,
// and a negedge monitor that checks every APB setup phase and every response.
module tb_apb_gpio_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_gpio_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } apb_t;

  rsp_t sb_q[$];
  apb_t apb_q[$];
  int   cyc_q[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   tb_wcnt = 0;
  int   slv_wait = 0;
  bit   gap_mode = 0;
  apb_t cur;

  initial begin
    PCLK = 0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: PREADY goes high after slv_wait low ACCESS cycles.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tb_wcnt <= 0;
    else if (PSEL && PENABLE && !PREADY) tb_wcnt <= tb_wcnt + 1;
    else if (!(PSEL && PENABLE)) tb_wcnt <= 0;
  end
  assign PREADY = (tb_wcnt >= slv_wait);

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input int id, input logic [31:0] rd,
                         input logic er, input int acc);
    rsp_t r;
    r.id = id; r.rdata = rd; r.err = er; r.acc = acc;
    sb_q.push_back(r);
  endtask

  task automatic exp_apb(input logic [3:0] a, input logic wr,
                         input logic [3:0] s, input logic [31:0] d);
    apb_t t;
    t.addr = a; t.wr = wr; t.strb = s; t.wdata = d;
    apb_q.push_back(t);
  endtask

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      acc_cnt = 0;
    end else begin
      if (PSEL && !PENABLE) begin
        if (apb_q.size() == 0) begin
          chk("unexpected_setup", 1, 0);
        end else begin
          cur = apb_q.pop_front();
          chk("setup_addr", PADDR, cur.addr);
          chk("setup_write", PWRITE, cur.wr);
          chk("setup_strb", PSTRB, cur.strb);
          chk("setup_wdata", PWDATA, cur.wdata);
          chk("setup_busy", busy, 1);
        end
      end
      if (PSEL && PENABLE) begin
        acc_cnt++;
        chk("access_stable",
            {PADDR, PWRITE, PSTRB, PWDATA},
            {cur.addr, cur.wr, cur.strb, cur.wdata});
      end
      if (rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", {62'd0, rsp_valid}, 0);
        end else begin
          rsp_t r;
          r = sb_q.pop_front();
          chk("rsp_id", {62'd0, rsp_valid}, 64'd1 << r.id);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_access_cycles", acc_cnt, r.acc);
          chk("rsp_bus_idle", {PSEL, PENABLE, busy}, 0);
        end
        acc_cnt = 0;
        if (gap_mode) cyc_q.push_back(cyc);
      end
    end
  end

  task automatic issue(input int id, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 0;
    req_write[id] = wr;
    req_addr[id*4 +: 4] = a;
    req_wdata[id*32 +: 32] = d;
    req_strb[id*4 +: 4] = s;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (req_ready[id]) done = 1;
      @(posedge PCLK);
      #1;
    end
    req_valid[id] = 1'b0;
    if (!done) chk("grant_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || apb_q.size() != 0) && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    chk("drain_pending", sb_q.size() + apb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 0;
    req_valid = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn = 0;
    req_valid = 0; req_write = 0; req_addr = 0;
    req_wdata = 0; req_strb = 0;
    PRDATA = 32'h0; PSLVERR = 0;
    #3;
    chk("reset_apb_ctrl", {PSEL, PENABLE, PWRITE, busy}, 0);
    chk("reset_apb_data", {PADDR, PSTRB, PWDATA}, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_ready", req_ready, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1;
    @(posedge PCLK);
    #1;

    // 1: single write from requester 0, cycle-exact
    exp_apb(4'd2, 1'b1, 4'hF, 32'h0000_00A5);
    exp_rsp(0, 32'h0, 1'b0, 1);
    req_write[0] = 1; req_addr[3:0] = 4'd2;
    req_wdata[31:0] = 32'hA5; req_strb[3:0] = 4'hF;
    req_valid[0] = 1;
    #1;
    chk("t1_ready_c0", req_ready, 2'b01);
    @(posedge PCLK);
    #1;
    req_valid[0] = 0;
    chk("t1_setup_c1", {PSEL, PENABLE}, 2'b10);
    @(posedge PCLK);
    #1;
    chk("t1_access_c2", {PSEL, PENABLE, PADDR, PSTRB}, {2'b11, 4'd2, 4'hF});
    @(posedge PCLK);
    #1;
    chk("t1_rsp_c3", {rsp_valid, rsp_err}, {2'b01, 1'b0});
    drain();

    // 2: read from requester 1, strobes forced low
    PRDATA = 32'h1234_5678;
    exp_apb(4'd8, 1'b0, 4'h0, 32'hDEAD_BEEF);
    exp_rsp(1, 32'h1234_5678, 1'b0, 1);
    issue(1, 1'b0, 4'd8, 32'hDEAD_BEEF, 4'hF);
    drain();

    // 3: continuous contention from reset, four transfers
    do_reset();
    PRDATA = 32'hCAFE_0001;
    exp_apb(4'd1, 1'b1, 4'h3, 32'h1111_0000);
    exp_rsp(0, 32'h0, 1'b0, 1);
    exp_apb(4'd4, 1'b0, 4'h0, 32'h2222_0000);
    exp_rsp(1, 32'hCAFE_0001, 1'b0, 1);
    exp_apb(4'd3, 1'b1, 4'hC, 32'h1111_0001);
    exp_rsp(0, 32'h0, 1'b0, 1);
    exp_apb(4'd5, 1'b0, 4'h0, 32'h2222_0001);
    exp_rsp(1, 32'hCAFE_0001, 1'b0, 1);
    cyc_q.delete();
    gap_mode = 1;
    fork
      begin
        issue(0, 1'b1, 4'd1, 32'h1111_0000, 4'h3);
        issue(0, 1'b1, 4'd3, 32'h1111_0001, 4'hC);
      end
      begin
        issue(1, 1'b0, 4'd4, 32'h2222_0000, 4'h7);
        issue(1, 1'b0, 4'd5, 32'h2222_0001, 4'h7);
      end
    join
    drain();
    gap_mode = 0;
    chk("t3_rsp_count", cyc_q.size(), 4);
    for (int i = 1; i < cyc_q.size(); i++)
      chk("t3_rsp_gap", cyc_q[i] - cyc_q[i-1], 3);

    // 4: three wait states then slave error
    slv_wait = 3;
    PSLVERR = 1;
    exp_apb(4'd6, 1'b1, 4'h5, 32'h5A5A_5A5A);
    exp_rsp(0, 32'h0, 1'b1, 4);
    issue(0, 1'b1, 4'd6, 32'h5A5A_5A5A, 4'h5);
    drain();
    PSLVERR = 0;

    // 5: hung slave times out, next transfer is normal
    slv_wait = 1000;
    PRDATA = 32'hFFFF_0000;
    exp_apb(4'd9, 1'b0, 4'h0, 32'h0);
    exp_rsp(1, 32'h0, 1'b1, 16);
    issue(1, 1'b0, 4'd9, 32'h0, 4'h0);
    drain();
    slv_wait = 0;
    PRDATA = 32'h0BAD_F00D;
    exp_apb(4'd10, 1'b0, 4'h0, 32'h0);
    exp_rsp(0, 32'h0BAD_F00D, 1'b0, 1);
    issue(0, 1'b0, 4'd10, 32'h0, 4'h0);
    drain();

    // 6: reset during ACCESS, then contention restarts at requester 0
    slv_wait = 1000;
    exp_apb(4'd7, 1'b1, 4'hF, 32'h7777_7777);
    issue(1, 1'b1, 4'd7, 32'h7777_7777, 4'hF);
    repeat (3) @(negedge PCLK);
    chk("t6_in_access", {PSEL, PENABLE}, 2'b11);
    PRESETn = 0;
    #1;
    chk("t6_reset_apb", {PSEL, PENABLE, busy}, 0);
    chk("t6_reset_rsp", rsp_valid, 0);
    @(negedge PCLK);
    chk("t6_reset_hold", {PSEL, PENABLE, rsp_valid}, 0);
    slv_wait = 0;
    PRDATA = 32'h0000_0042;
    PRESETn = 1;
    @(posedge PCLK);
    #1;
    exp_apb(4'd11, 1'b1, 4'h1, 32'hAAAA_0000);
    exp_rsp(0, 32'h0, 1'b0, 1);
    exp_apb(4'd12, 1'b0, 4'h0, 32'hBBBB_0000);
    exp_rsp(1, 32'h0000_0042, 1'b0, 1);
    fork
      issue(0, 1'b1, 4'd11, 32'hAAAA_0000, 4'h1);
      issue(1, 1'b0, 4'd12, 32'hBBBB_0000, 4'h2);
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_gpio_arbiter.md
Name: apb_gpio_arbiter

Overview:
Two-requester APB master arbiter that shares the single APB slave port of the GPIO peripheral (4-bit PADDR, 32-bit data) between two on-chip masters, e.g. a CPU bridge and a DMA/sequencer.
- Each requester issues one command through a valid/ready handshake.
- The block arbitrates round-robin and runs a full APB setup/access transfer.
- It returns a one-cycle response (read data, error) to the owning requester.
- A wait-state timeout turns a hung slave into an error response.

Parameters:
ADDR_W, 4, APB address width (PADDR, req_addr slice width)
DATA_W, 32, APB data width; PSTRB width is DATA_W/8
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  system clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  2  bit i: requester i has a command
req_ready  out  2  bit i: command i accepted this cycle (combinational)
req_write  in  2  bit i: 1=write, 0=read
req_addr  in  2*ADDR_W  slice i: target register address
req_wdata  in  2*DATA_W  slice i: write data
req_strb  in  2*DATA_W/8  slice i: byte strobes
rsp_valid  out  2  bit i: one-cycle response pulse to requester i
rsp_rdata  out  DATA_W  read data, shared by both requesters, qualified by rsp_valid
rsp_err  out  1  error flag (PSLVERR or timeout), qualified by rsp_valid
busy  out  1  transfer in progress (state != IDLE)
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PSTRB  out  DATA_W/8  APB strobes
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- The clock and reset are named PCLK and PRESETn. There is one clock, PCLK. Reset PRESETn is asynchronous and active-low.
- State machine: IDLE -> SETUP -> ACCESS -> IDLE.
- Reset values:
  - state=IDLE
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PSTRB=0, PWDATA=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0
  - last_grant=1, so requester 0 wins the first contention
  - wait counter=0
- IDLE:
  - If any req_valid is high, grant as follows:
    - Only one valid: grant that one.
    - Both valid: grant the requester != last_grant.
  - req_ready[g]=1 combinationally in that cycle only; req_ready is 0 in all other states.
  - Capture addr/write/wdata/strb of requester g into PADDR/PWRITE/PWDATA/PSTRB.
  - PSTRB is forced to 0 on reads.
  - Update last_grant=g and go to SETUP.
- SETUP: PSEL=1, PENABLE=0; always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1: register rsp_rdata=PRDATA (or 0 on writes), rsp_err=PSLVERR, pulse rsp_valid[g] in the next cycle, drop PSEL/PENABLE, go to IDLE.
  - If PREADY=0: increment the wait counter.
  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT while PREADY=0, abort. Drop PSEL/PENABLE, set rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - The counter clears on entry to SETUP.
- PADDR/PWRITE/PSTRB/PWDATA are stable from SETUP through the final ACCESS cycle. They hold their last value in IDLE.
- rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err hold until the next response.
- Back-to-back operation: a new request may be accepted in the same IDLE cycle that rsp_valid pulses. Throughput with a zero-wait slave is one transfer per 3 cycles, with no idle gap beyond IDLE.
- A requester must hold req_valid and payload until req_ready. Deasserting req_valid before grant is permitted; no command is taken.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously). No rsp_valid is issued for the aborted command. last_grant returns to 1.
- busy=1 in SETUP and ACCESS, 0 in IDLE.

Test Plan:
1. Reset, then req0 write addr=2 wdata=0x0000_00A5 strb=0xF, PREADY tied 1 -> req_ready[0] in cycle 0; PSEL=1/PENABLE=0 cycle 1; PSEL=1/PENABLE=1, PADDR=2, PSTRB=0xF cycle 2; rsp_valid[0]=1, rsp_err=0 cycle 3.
2. req1 read addr=8, slave PRDATA=0x1234_5678 -> PSTRB=0, PWRITE=0; rsp_valid[1] with rsp_rdata=0x1234_5678; rsp_valid[0] stays 0.
3. Both valid continuously for 4 transfers from reset -> grant order 0,1,0,1; each transfer 3 cycles apart; no request is lost or duplicated.
4. Slave holds PREADY=0 for 3 cycles, then PREADY=1 with PSLVERR=1 -> address/data stable throughout; rsp_err=1 on the response.
5. TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles; PSEL drops; rsp_valid=1, rsp_err=1, rsp_rdata=0; the next request proceeds normally.
6. Assert PRESETn low during ACCESS -> PSEL/PENABLE=0 immediately, no rsp_valid; after release, a contending pair grants req0 first.
